// File: rtl/rst_seq_pkg.sv
// Shared types, defaults and width helpers for the sequenced reset generator.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    STRETCH,
    RELEASE,
    DONE
  } rst_state_e;

  localparam int DEF_NUM_STAGES = 2;
  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_MIN_HOLD   = 4;
  localparam int DEF_SPACING    = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int p = 1; p < value; p = p * 2) begin
      result++;
    end
    return result;
  endfunction

  // One spare bit so the counter never has to wrap to hold its largest load value.
  function automatic int cntWidth(input int minHold, input int spacing);
    return clog2((minHold > spacing) ? minHold : spacing) + 1;
  endfunction

  function automatic int idxWidth(input int numCh);
    return clog2(numCh) + 1;
  endfunction

  localparam int DEF_CNT_W = cntWidth(DEF_MIN_HOLD, DEF_SPACING);
  localparam int DEF_IDX_W = idxWidth(DEF_NUM_CH);

endpackage

// File: rtl/rst_seq_sync_if.sv
// Request/status bundle between a reset sequencer (slave) and its controller (master).
interface rst_seq_sync_if
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
);

  logic              SW_RST_REQ;
  logic [NUM_CH-1:0] SYNC_RST;
  logic              RST_DONE;

  modport master (output SW_RST_REQ, input SYNC_RST, input RST_DONE);
  modport slave  (input SW_RST_REQ, output SYNC_RST, output RST_DONE);

endinterface

// File: rtl/rst_sync_chain.sv
// Reset synchronizer: asserts asynchronously, deasserts NUM_STAGES clock edges after RST drops.
module rst_sync_chain
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rstSync
);

  logic [NUM_STAGES-1:0] r_stages;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stages <= '1;
    end else begin
      r_stages <= {r_stages[NUM_STAGES-2:0], 1'b0};
    end
  end

  assign o_rstSync = r_stages[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Sequenced reset generator: synchronizes RST release, stretches it to MIN_HOLD
// cycles, then frees NUM_CH reset channels SPACING cycles apart.
module rst_seq_sync
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int MIN_HOLD   = DEF_MIN_HOLD,
  parameter int SPACING    = DEF_SPACING
) (
  input  logic          CLK,
  input  logic          RST,
  rst_seq_sync_if.slave bus
);

  localparam int CNT_W = cntWidth(MIN_HOLD, SPACING);
  localparam int IDX_W = idxWidth(NUM_CH);

  // Leaving HOLD already costs one edge after the synchronizer drops, hence MIN_HOLD-2.
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'((MIN_HOLD >= 2) ? (MIN_HOLD - 2) : 0);
  localparam logic [CNT_W-1:0] SW_LOAD    = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] SPACE_LOAD = CNT_W'(SPACING - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] END_IDX    = IDX_W'(NUM_CH);

  logic              w_rstSync;
  rst_state_e        r_state;
  rst_state_e        w_stateNxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cntNxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idxNxt;
  logic [NUM_CH-1:0] r_syncRst;
  logic [NUM_CH-1:0] w_syncRstNxt;
  logic              r_rstDone;
  logic              w_rstDoneNxt;
  logic              w_clearCh;

  rst_sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_syncChain (
    .i_clk    (CLK),
    .i_rst    (RST),
    .o_rstSync(w_rstSync)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_syncRst <= '1;
      r_rstDone <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_cnt     <= w_cntNxt;
      r_idx     <= w_idxNxt;
      r_syncRst <= w_syncRstNxt;
      r_rstDone <= w_rstDoneNxt;
    end
  end

  always_comb begin
    w_stateNxt   = r_state;
    w_cntNxt     = r_cnt;
    w_idxNxt     = r_idx;
    w_syncRstNxt = r_syncRst;
    w_rstDoneNxt = r_rstDone;
    w_clearCh    = 1'b0;

    case (r_state)
      HOLD: begin
        if (!w_rstSync) begin
          if (MIN_HOLD == 1) begin
            w_clearCh = 1'b1;
          end else begin
            w_stateNxt = STRETCH;
            w_cntNxt   = HOLD_LOAD;
          end
        end
      end
      STRETCH, RELEASE: begin
        if (r_cnt == '0) begin
          w_clearCh = 1'b1;
        end else begin
          w_cntNxt = r_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        w_rstDoneNxt = 1'b1;
      end
      default: ;
    endcase

    // r_idx always names the next channel to free; it parks at NUM_CH once all are free.
    if (w_clearCh) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_idx == IDX_W'(i)) begin
          w_syncRstNxt[i] = 1'b0;
        end
      end
      w_cntNxt = SPACE_LOAD;
      if (r_idx == LAST_IDX) begin
        w_stateNxt = DONE;
        w_idxNxt   = END_IDX;
      end else begin
        w_stateNxt = RELEASE;
        w_idxNxt   = r_idx + IDX_W'(1);
      end
    end

    if (bus.SW_RST_REQ && (r_state != HOLD)) begin
      w_stateNxt   = STRETCH;
      w_cntNxt     = SW_LOAD;
      w_idxNxt     = '0;
      w_syncRstNxt = '1;
      w_rstDoneNxt = 1'b0;
    end
  end

  assign bus.SYNC_RST = r_syncRst;
  assign bus.RST_DONE = r_rstDone;

endmodule

// File: tb/tb_rst_seq_sync.sv
// Scoreboard bench for rst_seq_sync: default configuration plus a minimal-parameter
// instance, both driven by the same RST and software request.
module tb_rst_seq_sync;

  localparam int MAIN_N  = 2;
  localparam int MAIN_MH = 4;
  localparam int MAIN_SP = 2;
  localparam int MAIN_NC = 3;
  localparam int SWP_N   = 3;
  localparam int SWP_MH  = 1;
  localparam int SWP_SP  = 1;
  localparam int SWP_NC  = 1;

  typedef struct packed {
    logic [2:0] sync;
    logic       done;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  rst_seq_sync_if #(.NUM_CH(MAIN_NC)) mainBus ();
  rst_seq_sync_if #(.NUM_CH(SWP_NC))  swpBus ();

  rst_seq_sync #(
    .NUM_STAGES(MAIN_N),
    .NUM_CH    (MAIN_NC),
    .MIN_HOLD  (MAIN_MH),
    .SPACING   (MAIN_SP)
  ) dutMain (
    .CLK(CLK),
    .RST(RST),
    .bus(mainBus.slave)
  );

  rst_seq_sync #(
    .NUM_STAGES(SWP_N),
    .NUM_CH    (SWP_NC),
    .MIN_HOLD  (SWP_MH),
    .SPACING   (SWP_SP)
  ) dutSweep (
    .CLK(CLK),
    .RST(RST),
    .bus(swpBus.slave)
  );

  int cfgN  [2] = '{MAIN_N,  SWP_N};
  int cfgMh [2] = '{MAIN_MH, SWP_MH};
  int cfgSp [2] = '{MAIN_SP, SWP_SP};
  int cfgNc [2] = '{MAIN_NC, SWP_NC};

  // Reference model: edges elapsed since the sequence's reference point, where the
  // reference is edge N after an async release or edge S of an accepted request.
  int sinceRef [2];
  bit inHold   [2];

  exp_t qMain[$];
  exp_t qSwp[$];

  int compared   = 0;
  int mismatched = 0;

  function automatic exp_t expectAt(input int c);
    exp_t e;
    e = '0;
    for (int i = 0; i < cfgNc[c]; i++) begin
      e.sync[i] = (sinceRef[c] < cfgMh[c] + i * cfgSp[c]);
    end
    e.done = (sinceRef[c] >= cfgMh[c] + (cfgNc[c] - 1) * cfgSp[c] + 1);
    return e;
  endfunction

  task automatic modelAsyncReset();
    for (int c = 0; c < 2; c++) begin
      sinceRef[c] = -cfgN[c];
      inHold[c]   = 1'b1;
    end
  endtask

  task automatic pushEdge(input bit rstVal, input bit swVal);
    for (int c = 0; c < 2; c++) begin
      if (rstVal) begin
        sinceRef[c] = -cfgN[c];
        inHold[c]   = 1'b1;
      end else begin
        if (swVal && !inHold[c]) sinceRef[c] = 0;
        else sinceRef[c]++;
        if (sinceRef[c] >= 1) inHold[c] = 1'b0;
      end
    end
    qMain.push_back(expectAt(0));
    qSwp.push_back(expectAt(1));
  endtask

  task automatic checkOutput(input string name, input logic [2:0] actSync, input logic actDone,
                             input exp_t want);
    compared++;
    if ((actSync !== want.sync) || (actDone !== want.done)) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got SYNC_RST=%b RST_DONE=%b, expected SYNC_RST=%b RST_DONE=%b",
               name, $time, actSync, actDone, want.sync, want.done);
    end
  endtask

  task automatic checkAsync(input string name);
    checkOutput({name, "Main"}, mainBus.SYNC_RST, mainBus.RST_DONE, expectAt(0));
    checkOutput({name, "Sweep"}, {2'b00, swpBus.SYNC_RST}, swpBus.RST_DONE, expectAt(1));
  endtask

  task automatic applyStimulus(input bit rstVal, input bit swVal);
    @(negedge CLK);
    mainBus.SW_RST_REQ = swVal;
    swpBus.SW_RST_REQ  = swVal;
    if (rstVal && !RST) begin
      RST = 1'b1;
      modelAsyncReset();
      #1;
      checkAsync("rstAssert");
    end else begin
      RST = rstVal;
    end
    pushEdge(rstVal, swVal);
  endtask

  // A 3 ns RST pulse inside the low clock phase, finished before the next rising edge.
  task automatic applyGlitch(input bit swVal);
    @(negedge CLK);
    mainBus.SW_RST_REQ = swVal;
    swpBus.SW_RST_REQ  = swVal;
    #1;
    RST = 1'b1;
    modelAsyncReset();
    #1;
    checkAsync("glitch");
    #2;
    RST = 1'b0;
    pushEdge(1'b0, swVal);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (qMain.size() > 0)
        checkOutput("mainSeq", mainBus.SYNC_RST, mainBus.RST_DONE, qMain.pop_front());
      if (qSwp.size() > 0)
        checkOutput("sweepSeq", {2'b00, swpBus.SYNC_RST}, swpBus.RST_DONE, qSwp.pop_front());
    end
  end

  initial begin
    int rstLeft;
    bit rstVal;
    bit swVal;

    mainBus.SW_RST_REQ = 1'b0;
    swpBus.SW_RST_REQ  = 1'b0;
    #1;
    RST = 1'b1;
    modelAsyncReset();
    #1;
    checkAsync("resetState");

    $display("[TB] power-on sequence");
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0);
    idle(15);

    $display("[TB] glitch while done");
    applyGlitch(1'b0);
    idle(15);

    $display("[TB] reset reasserted mid-sequence");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    idle(7);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    idle(15);

    $display("[TB] software request in done, repeated during release");
    applyStimulus(1'b0, 1'b1);
    idle(4);
    applyStimulus(1'b0, 1'b1);
    idle(12);

    $display("[TB] software request held through reset");
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1);
    idle(15);

    $display("[TB] randomized traffic");
    rstLeft = 0;
    for (int k = 0; k < 400; k++) begin
      swVal = ($urandom_range(0, 7) == 0);
      if (rstLeft == 0 && $urandom_range(0, 79) == 0) begin
        applyGlitch(swVal);
      end else begin
        if (rstLeft == 0 && $urandom_range(0, 59) == 0) rstLeft = $urandom_range(1, 5);
        rstVal = (rstLeft > 0);
        if (rstLeft > 0) rstLeft--;
        applyStimulus(rstVal, swVal);
      end
    end
    idle(20);

    @(posedge CLK);
    #2;
    compared++;
    if ((qMain.size() != 0) || (qSwp.size() != 0)) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d/%0d pending expectations, expected 0/0",
               qMain.size(), qSwp.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
